// File: rtl/adc_align_pkg.sv
// adc_align_pkg: shared state encoding, default frame pattern and rotation test for ADC link training
package adc_align_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_NEXT, S_CENTER,
    S_SLIP, S_SLIPWAIT, S_VERIFY, S_LOCKED, S_FAIL
  } align_st_t;
  localparam logic [7:0] FRM_PAT_DEF = 8'hF0;
  function automatic logic is_rot(input logic [7:0] word, input logic [7:0] pat);
    logic [15:0] d;
    d = {pat, pat};
    is_rot = 1'b0;
    for (int i = 0; i < 8; i++) is_rot = is_rot | (d[i +: 8] == word);
  endfunction
endpackage

// File: rtl/adc_align_win.sv
// adc_align_win: tracks the longest contiguous run of good taps; ties keep the earlier run
module adc_align_win #(
  parameter int TW = 5
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          clear,
  input  logic          valid,
  input  logic          good,
  input  logic [TW-1:0] tap,
  output logic [TW-1:0] best_start,
  output logic [TW:0]   best_len
);
  logic [TW-1:0] cur_start, run_start;
  logic [TW:0]   cur_len, run_len;
  always_comb begin
    run_start = cur_len == '0 ? tap : cur_start;
    run_len   = cur_len + 1'b1;
  end
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i || clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      cur_start <= good ? run_start : cur_start;
      cur_len   <= good ? run_len : '0;
      if (good && run_len > best_len) begin
        best_start <= run_start;
        best_len   <= run_len;
      end
    end
  end
endmodule

// File: rtl/adc_align_ctrl.sv
// adc_align_ctrl: sweeps delay taps for the widest stable eye, centres, bitslips to the frame pattern, monitors lock
module adc_align_ctrl
  import adc_align_pkg::*;
#(
  parameter int         TAPS    = 32,
  parameter int         SETTLE  = 16,
  parameter int         N_CHK   = 64,
  parameter logic [7:0] FRM_PAT = FRM_PAT_DEF,
  parameter int         MIN_WIN = 4,
  parameter int         ERR_MAX = 4,
  localparam int        TW      = $clog2(TAPS)
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          start_i,
  input  logic [7:0]    fclk_par_i,
  output logic [TW-1:0] dly_tap_o,
  output logic          dly_ld_o,
  output logic          bitslip_o,
  output logic          busy_o,
  output logic          locked_o,
  output logic          fail_o,
  output logic [TW:0]   win_o,
  output logic [15:0]   err_cnt_o
);
  localparam int CW = $clog2(SETTLE > N_CHK ? SETTLE : N_CHK);
  localparam int EW = $clog2(ERR_MAX + 1);
  align_st_t     st, nxt;
  logic [TW-1:0] tap, best_start;
  logic [TW:0]   best_len;
  logic [CW-1:0] cnt;
  logic [EW-1:0] consec;
  logic [7:0]    cap;
  logic [2:0]    slips;
  logic          ok, ctr_ph, mis, set_last, chk_last, retrain, slip_go;

  adc_align_win #(.TW(TW)) u_win (
    .adc_clk_i  (adc_clk_i),
    .adc_rstn_i (adc_rstn_i),
    .clear      (start_i | retrain),
    .valid      (st == S_NEXT && !start_i),
    .good       (ok),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_ff @(posedge adc_clk_i) st <= !adc_rstn_i ? S_IDLE : nxt;

  always_comb begin
    mis      = fclk_par_i != FRM_PAT;
    set_last = cnt == CW'(SETTLE - 1);
    chk_last = cnt == CW'(N_CHK - 1);
    retrain  = st == S_LOCKED && mis && consec == EW'(ERR_MAX - 1);
    slip_go  = st == S_SLIP && mis && slips != 3'd7;
    nxt      = st;
    case (st)
      S_IDLE:     nxt = S_IDLE;
      S_LOAD:     nxt = S_SETTLE;
      S_SETTLE:   nxt = !set_last ? S_SETTLE : ctr_ph ? S_SLIP : S_CHECK;
      S_CHECK:    nxt = chk_last ? S_NEXT : S_CHECK;
      S_NEXT:     nxt = tap == TW'(TAPS - 1) ? S_CENTER : S_LOAD;
      S_CENTER:   nxt = best_len < (TW + 1)'(MIN_WIN) ? S_FAIL : S_LOAD;
      S_SLIP:     nxt = !mis ? S_VERIFY : slip_go ? S_SLIPWAIT : S_FAIL;
      S_SLIPWAIT: nxt = set_last ? S_SLIP : S_SLIPWAIT;
      S_VERIFY:   nxt = mis ? S_FAIL : chk_last ? S_LOCKED : S_VERIFY;
      S_LOCKED:   nxt = retrain ? S_LOAD : S_LOCKED;
      S_FAIL:     nxt = S_FAIL;
      default:    nxt = S_IDLE;
    endcase
    if (start_i) nxt = S_LOAD;
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      cnt       <= '0;
      tap       <= '0;
      dly_tap_o <= '0;
      dly_ld_o  <= 1'b0;
      bitslip_o <= 1'b0;
      busy_o    <= 1'b0;
      locked_o  <= 1'b0;
      fail_o    <= 1'b0;
      win_o     <= '0;
      err_cnt_o <= '0;
      consec    <= '0;
      cap       <= '0;
      ok        <= 1'b0;
      slips     <= '0;
      ctr_ph    <= 1'b0;
    end else begin
      cnt       <= nxt != st ? '0 : cnt + 1'b1;
      dly_ld_o  <= st == S_LOAD && !start_i;
      bitslip_o <= slip_go && !start_i;
      busy_o    <= !(nxt inside {S_IDLE, S_LOCKED, S_FAIL});
      locked_o  <= nxt == S_LOCKED;
      fail_o    <= nxt == S_FAIL;
      if (st == S_LOAD && !start_i) dly_tap_o <= tap;
      // first CHECK word is the reference; the rest must repeat it
      if (st == S_CHECK) begin
        cap <= cnt == '0 ? fclk_par_i : cap;
        ok  <= cnt == '0 ? is_rot(fclk_par_i, FRM_PAT) : ok && fclk_par_i == cap;
      end
      if (start_i || retrain) begin
        tap    <= '0;
        win_o  <= '0;
        slips  <= '0;
        consec <= '0;
        ctr_ph <= 1'b0;
      end else begin
        if (st == S_NEXT && nxt == S_LOAD) tap <= tap + 1'b1;
        if (st == S_CENTER && nxt == S_LOAD) begin
          tap    <= best_start + best_len[TW:1];
          win_o  <= best_len;
          ctr_ph <= 1'b1;
        end
        if (slip_go) slips <= slips + 1'b1;
        if (st == S_LOCKED) consec <= mis ? consec + 1'b1 : '0;
      end
      if (start_i) err_cnt_o <= '0;
      else if (st == S_LOCKED && mis && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_align_ctrl.sv
// tb_adc_align_ctrl: scoreboard bench with a tap/bitslip ADC model; outcomes and timed probes are queued and checked by a monitor
module tb_adc_align_ctrl;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [7:0]  fclk;
  logic [4:0]  tap;
  logic [5:0]  win;
  logic [15:0] err;
  logic        ld, bs, busy, locked, fail;

  always #5 clk = ~clk;

  adc_align_ctrl dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rstn),
    .start_i    (start),
    .fclk_par_i (fclk),
    .dly_tap_o  (tap),
    .dly_ld_o   (ld),
    .bitslip_o  (bs),
    .busy_o     (busy),
    .locked_o   (locked),
    .fail_o     (fail),
    .win_o      (win),
    .err_cnt_o  (err)
  );

  typedef struct {
    string       name;
    int          at;
    int          dl;
    logic [31:0] exp;
    int          slips;
  } item_t;

  item_t       oq[$];
  item_t       pq[$];
  int          cyc = 0, n_tests = 0, n_fail = 0, slip_total = 0, slip_base = 0;
  logic [31:0] mask = '0;
  logic [7:0]  base = 8'hF0;
  logic        stuck = 1'b0, inj = 1'b0, lk_q = 1'b0, fl_q = 1'b0;
  logic [4:0]  cur_tap = '0;
  int          nslip = 0;

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < n % 8; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] mk(input logic lk, input logic fl, input logic bz, input logic l,
                                     input logic b, input logic [4:0] t, input logic [5:0] w,
                                     input logic [15:0] e);
    return {lk, fl, bz, l, b, t, w, e};
  endfunction

  function logic [31:0] snap();
    return {locked, fail, busy, ld, bs, tap, win, err};
  endfunction

  // Bad taps wander between two rotations so only the stability test rejects them
  assign fclk = !mask[cur_tap] ? (cyc[3] ? 8'h0F : 8'hF0) : inj ? 8'h00 : rotl(base, stuck ? 0 : nslip);

  always @(posedge clk) begin
    cur_tap <= ld ? tap : cur_tap;
    nslip   <= start ? 0 : nslip + int'(bs);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bs) slip_total++;
      if ((locked && !lk_q) || (fail && !fl_q)) begin
        if (oq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_outcome: got %h expected none", snap());
        end else begin
          e = oq.pop_front();
          chk(e.name, snap(), e.exp);
          chk({e.name, "_slips"}, 32'(slip_total - slip_base), 32'(e.slips));
        end
      end
      if (oq.size() != 0 && cyc > oq[0].dl) begin
        e = oq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no outcome by cycle %0d expected %h", e.name, cyc, e.exp);
      end
      while (pq.size() != 0 && pq[0].at <= cyc) begin
        e = pq.pop_front();
        chk(e.name, snap(), e.exp);
      end
      lk_q = locked;
      fl_q = fail;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] exp, input int slips);
    item_t e;
    e.name = nm; e.at = 0; e.dl = cyc + 6000; e.exp = exp; e.slips = slips;
    oq.push_back(e);
  endtask

  task automatic probe(input string nm, input int k, input logic [31:0] exp);
    item_t e;
    e.name = nm; e.at = cyc + k; e.dl = 0; e.exp = exp; e.slips = 0;
    pq.push_back(e);
  endtask

  task automatic train(input logic [31:0] m, input logic [7:0] b, input logic s);
    mask = m; base = b; stuck = s; slip_base = slip_total;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain();
    while (oq.size() != 0 || pq.size() != 0) tick(1);
  endtask

  initial begin
    logic [7:0] ip;
    tick(3);
    probe("reset_state", 1, '0);
    tick(2);
    rstn = 1'b1;
    probe("idle_after_reset", 2, '0);
    tick(3);
    expect_out("lock_10_19", mk(1, 0, 0, 0, 0, 15, 10, 0), 0);
    train(rng(10, 19), 8'hF0, 1'b0);
    drain();
    // 3 bad, 1 good, 4 bad: the 4th consecutive mismatch forces retraining
    ip = 8'b1111_0111;
    probe("err6_still_locked", 8, mk(1, 0, 0, 0, 0, 15, 10, 6));
    probe("retrain_on_4th", 9, mk(0, 0, 1, 0, 0, 15, 0, 7));
    expect_out("relock_keeps_err", mk(1, 0, 0, 0, 0, 15, 10, 7), 0);
    for (int i = 0; i < 8; i++) begin
      inj = ip[i];
      tick(1);
    end
    inj = 1'b0;
    drain();
    expect_out("lock_20_27", mk(1, 0, 0, 0, 0, 24, 8, 0), 0);
    train(rng(3, 6) | rng(20, 27), 8'hF0, 1'b0);
    drain();
    expect_out("lock_1e_3slips", mk(1, 0, 0, 0, 0, 15, 10, 0), 3);
    train(rng(10, 19), 8'h1E, 1'b0);
    drain();
    expect_out("lock_78_1slip", mk(1, 0, 0, 0, 0, 15, 10, 0), 1);
    train(rng(10, 19), 8'h78, 1'b0);
    drain();
    expect_out("fail_no_match", mk(0, 1, 0, 0, 0, 15, 10, 0), 7);
    train(rng(10, 19), 8'h1E, 1'b1);
    drain();
    expect_out("fail_narrow_eye", mk(0, 1, 0, 0, 0, 31, 0, 0), 0);
    train(rng(5, 7), 8'hF0, 1'b0);
    drain();
    expect_out("lock_after_restart", mk(1, 0, 0, 0, 0, 15, 10, 0), 0);
    train(rng(10, 19), 8'hF0, 1'b0);
    tick(300);
    probe("restart_ld_tap0", 3, mk(0, 0, 1, 1, 0, 0, 0, 0));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    drain();
    train(rng(10, 19), 8'hF0, 1'b0);
    tick(500);
    probe("reset_mid_sweep", 2, '0);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(3);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1000000 ns expected finish");
    $fatal(1, "watchdog");
  end
endmodule
